// File: rtl/btn_event_gen.sv
// Per-button event generator: turns debounced levels into 1-cycle press/release/short/long/repeat pulses.
// Auto-repeat in HOLD is built only when BTN_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied low.
module btn_event_gen #(
  parameter int BTN_WIDTH     = 8,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_WIDTH-1:0] btn_deb,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] press_pulse,
  output logic [BTN_WIDTH-1:0] release_pulse,
  output logic [BTN_WIDTH-1:0] short_pulse,
  output logic [BTN_WIDTH-1:0] long_pulse,
  output logic [BTN_WIDTH-1:0] repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("btn_event_gen: LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("btn_event_gen: REPEAT_CYCLES must be at least 2");
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [BTN_WIDTH-1:0] pr;
  logic [BTN_WIDTH-1:0] rise;
  logic [BTN_WIDTH-1:0] fall;
  logic [BTN_WIDTH-1:0] prev_q;

  state_t           state_q [BTN_WIDTH];
  state_t           state_d [BTN_WIDTH];
  logic [CNT_W-1:0] cnt_q   [BTN_WIDTH];
  logic [CNT_W-1:0] cnt_d   [BTN_WIDTH];

  logic [BTN_WIDTH-1:0] press_q,   press_d;
  logic [BTN_WIDTH-1:0] release_q, release_d;
  logic [BTN_WIDTH-1:0] short_q,   short_d;
  logic [BTN_WIDTH-1:0] long_q,    long_d;
`ifdef BTN_AUTO_REPEAT_EN
  logic [BTN_WIDTH-1:0] repeat_q,  repeat_d;
`endif

  assign pr   = ACTIVE_LOW ? ~btn_deb : btn_deb;
  assign rise = pr & ~prev_q;
  assign fall = ~pr & prev_q;

  always_comb begin
    press_d   = '0;
    release_d = '0;
    short_d   = '0;
    long_d    = '0;
`ifdef BTN_AUTO_REPEAT_EN
    repeat_d  = '0;
`endif
    for (int i = 0; i < BTN_WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A fall always wins over a counter terminal reached on the same cycle.
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            press_d[i] = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = PRESS;
          end
        end
        PRESS: begin
          if (fall[i]) begin
            release_d[i] = 1'b1;
            short_d[i]   = 1'b1;
            state_d[i]   = IDLE;
          end else if (cnt_q[i] == LONG_TERM) begin
            long_d[i]  = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = HOLD;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HOLD: begin
          if (fall[i]) begin
            release_d[i] = 1'b1;
            state_d[i]   = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
          end else if (cnt_q[i] == REPEAT_TERM) begin
            repeat_d[i] = 1'b1;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
`else
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
`endif
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // prev_q tracks pr even in reset, so a button held through reset never looks like a new press.
  always_ff @(posedge clk) begin
    prev_q <= pr;
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
      short_q   <= '0;
      long_q    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_q  <= '0;
`endif
      for (int i = 0; i < BTN_WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
      for (int i = 0; i < BTN_WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level     = prev_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
`ifdef BTN_AUTO_REPEAT_EN
  assign repeat_pulse  = repeat_q;
`else
  assign repeat_pulse  = '0;
`endif

endmodule
